// File: rtl/bidir_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state data bus: grants one requester,
// enables its driver a cycle later, and enforces a turnaround gap plus a hold cap.
module bidir_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         drive_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        OWN  = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       w_rr_ptr_nxt;
    logic [IDW-1:0]       r_grant_id;
    logic [IDW-1:0]       w_grant_id_nxt;
    logic [7:0]           r_hold_cnt;
    logic [7:0]           w_hold_cnt_nxt;
    logic [2:0]           r_turn_cnt;
    logic [2:0]           w_turn_cnt_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [NUM_REQ-1:0]   r_drive_en;
    logic [NUM_REQ-1:0]   w_drive_en_nxt;
    logic                 r_busy;
    logic                 r_timeout;
    logic                 w_timeout_nxt;

    logic                 w_arb_found;
    logic [IDW-1:0]       w_arb_idx;
    logic [IDW-1:0]       w_ptr_inc;
    logic                 w_rel_other;
    logic                 w_rel_hold;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        return IDW'(v % NUM_REQ);
    endfunction

    assign w_ptr_inc   = (r_grant_id == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : r_grant_id + IDW'(1);
    assign w_rel_other = done[r_grant_id] | ~req[r_grant_id];
    assign w_rel_hold  = (r_hold_cnt == 8'(MAX_HOLD));

    // Round-robin search starting at rr_ptr, wrapping around the requester set.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_arb_found && req[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = wrap_idx(int'(r_rr_ptr) + k);
            end else begin
                w_arb_found = w_arb_found;
            end
        end
    end

    // Next-state and next-output logic for the ownership FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_hold_cnt_nxt = r_hold_cnt;
        w_turn_cnt_nxt = r_turn_cnt;
        w_grant_nxt    = r_grant;
        w_drive_en_nxt = r_drive_en;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt    = ARM;
                    w_grant_id_nxt = w_arb_idx;
                    w_grant_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_arb_idx;
                end else begin
                    w_state_nxt    = IDLE;
                end
            end
            ARM: begin
                if (req[r_grant_id]) begin
                    w_state_nxt    = OWN;
                    w_drive_en_nxt = r_grant;
                    w_hold_cnt_nxt = 8'd1;
                end else begin
                    // Bus was never driven, so no turnaround is needed.
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = {NUM_REQ{1'b0}};
                    w_rr_ptr_nxt   = w_ptr_inc;
                end
            end
            OWN: begin
                if (w_rel_other || w_rel_hold) begin
                    w_grant_nxt    = {NUM_REQ{1'b0}};
                    w_drive_en_nxt = {NUM_REQ{1'b0}};
                    w_rr_ptr_nxt   = w_ptr_inc;
                    w_hold_cnt_nxt = 8'd0;
                    w_timeout_nxt  = w_rel_hold & ~w_rel_other;
                    if (TURNAROUND == 0) begin
                        w_state_nxt    = IDLE;
                        w_turn_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt    = TURN;
                        w_turn_cnt_nxt = 3'(TURNAROUND);
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
            TURN: begin
                if (r_turn_cnt <= 3'd1) begin
                    w_state_nxt    = IDLE;
                    w_turn_cnt_nxt = 3'd0;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = {NUM_REQ{1'b0}};
                w_drive_en_nxt = {NUM_REQ{1'b0}};
                w_hold_cnt_nxt = 8'd0;
                w_turn_cnt_nxt = 3'd0;
            end
        endcase
    end

    // State and registered outputs; busy tracks the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= {IDW{1'b0}};
            r_grant_id <= {IDW{1'b0}};
            r_hold_cnt <= 8'd0;
            r_turn_cnt <= 3'd0;
            r_grant    <= {NUM_REQ{1'b0}};
            r_drive_en <= {NUM_REQ{1'b0}};
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_drive_en <= w_drive_en_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign grant    = r_grant;
    assign drive_en = r_drive_en;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

    bidir_bus_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .grant    (r_grant),
        .drive_en (r_drive_en)
    );

endmodule

// Bus-safety invariants: exclusive ownership and no direct driver-to-driver handoff.
module bidir_bus_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] grant,
    input  logic [NUM_REQ-1:0] drive_en
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_drive_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(drive_en));
    a_drive_in_grant: assert property (@(posedge clk) disable iff (rst)
        (drive_en & ~grant) == {NUM_REQ{1'b0}});
    a_no_direct_switch: assert property (@(posedge clk) disable iff (rst)
        (drive_en != {NUM_REQ{1'b0}} && $past(drive_en) != {NUM_REQ{1'b0}})
        |-> (drive_en == $past(drive_en)));

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// Scoreboard bench for bidir_bus_arbiter: a behavioural model queues expected
// outputs as each cycle's inputs are driven; they are compared after the edge.
module tb_bidir_bus_arbiter;

    localparam int N  = 4;
    localparam int TA = 1;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    wire  [3:0] grant;
    wire  [3:0] drive_en;
    wire  [1:0] grant_id;
    wire        busy;
    wire        timeout;

    bidir_bus_arbiter #(.NUM_REQ(N), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .drive_en (drive_en),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] d;
        logic [1:0] id;
        logic       b;
        logic       t;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 idle, 1 arm, 2 own, 3 turnaround
    int   m_st, m_owner, m_ptr, m_hold, m_turn;
    logic m_to;

    int         ids_seen[$];
    logic [3:0] prev_grant;
    int         run, max_run, n_to;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_turn = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic [3:0] dn);
        bit found;
        bit by_hold;
        bit by_other;
        m_to = 1'b0;
        if (m_st == 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && rq[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (found) m_st = 1;
        end else if (m_st == 1) begin
            if (rq[m_owner]) begin
                m_st = 2; m_hold = 1;
            end else begin
                m_st = 0; m_ptr = (m_owner + 1) % N;
            end
        end else if (m_st == 2) begin
            by_hold  = (m_hold == MH);
            by_other = dn[m_owner] || !rq[m_owner];
            if (by_hold || by_other) begin
                m_ptr = (m_owner + 1) % N;
                m_to  = by_hold && !by_other;
                if (TA == 0) m_st = 0;
                else begin m_st = 3; m_turn = TA; end
            end else begin
                m_hold++;
            end
        end else begin
            if (m_turn <= 1) m_st = 0;
            else m_turn--;
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        logic [3:0] oh;
        oh   = 4'b0001 << m_owner;
        e.g  = (m_st == 1 || m_st == 2) ? oh : 4'b0000;
        e.d  = (m_st == 2) ? oh : 4'b0000;
        e.id = 2'(m_owner);
        e.b  = (m_st != 0);
        e.t  = m_to;
        return e;
    endfunction

    task automatic cycle(input logic [3:0] rq, input logic [3:0] dn);
        exp_t e;
        @(negedge clk);
        req  = rq;
        done = dn;
        model_step(rq, dn);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("grant",    {28'd0, grant},    {28'd0, e.g});
        check_val("drive_en", {28'd0, drive_en}, {28'd0, e.d});
        check_val("grant_id", {30'd0, grant_id}, {30'd0, e.id});
        check_val("busy",     {31'd0, busy},     {31'd0, e.b});
        check_val("timeout",  {31'd0, timeout},  {31'd0, e.t});
        if (grant != 4'b0000 && prev_grant == 4'b0000) ids_seen.push_back(int'(grant_id));
        prev_grant = grant;
        run = (drive_en != 4'b0000) ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (timeout === 1'b1) n_to++;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_grant"},   {28'd0, grant},    32'd0);
        check_val({tag, "_drive"},   {28'd0, drive_en}, 32'd0);
        check_val({tag, "_id"},      {30'd0, grant_id}, 32'd0);
        check_val({tag, "_busy"},    {31'd0, busy},     32'd0);
        check_val({tag, "_timeout"}, {31'd0, timeout},  32'd0);
    endtask

    initial begin
        logic [3:0] dn;
        int         exp_order[5];
        exp_order  = '{2, 3, 0, 1, 2};
        rst        = 1'b1;
        req        = 4'b0000;
        done       = 4'b0000;
        prev_grant = 4'b0000;
        run = 0; max_run = 0; n_to = 0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        repeat (3) cycle(4'b0000, 4'b0000);

        // Idle grant latency and round-robin handoff order
        ids_seen.delete();
        cycle(4'b0100, 4'b0000);
        check_val("lat_grant", {28'd0, grant}, 32'h4);
        check_val("lat_drive0", {28'd0, drive_en}, 32'h0);
        cycle(4'b0100, 4'b0000);
        check_val("lat_drive", {28'd0, drive_en}, 32'h4);
        for (int c = 0; c < 30; c++) begin
            dn = (m_st == 2 && m_hold == 3) ? (4'b0001 << m_owner) : 4'b0000;
            cycle(4'b1111, dn);
        end
        check_val("order_cnt", {31'd0, ids_seen.size() >= 5}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < ids_seen.size()) check_val("order", ids_seen[i], exp_order[i]);
        end
        repeat (10) cycle(4'b0000, 4'b0000);

        // Hold timeout with a single persistent requester
        run = 0; max_run = 0; n_to = 0;
        repeat (45) cycle(4'b0001, 4'b0000);
        check_val("max_hold_run", max_run, MH);
        check_val("timeout_cnt", n_to, 2);
        repeat (10) cycle(4'b0000, 4'b0000);

        // Request withdrawn during ARM
        cycle(4'b0010, 4'b0000);
        check_val("arm_grant", {28'd0, grant}, 32'h2);
        cycle(4'b0000, 4'b0000);
        check_val("arm_drop_busy", {31'd0, busy}, 32'd0);
        check_val("arm_drop_drive", {28'd0, drive_en}, 32'h0);
        cycle(4'b1111, 4'b0000);
        check_val("arm_drop_ptr", {30'd0, grant_id}, 32'd2);
        cycle(4'b0000, 4'b0000);

        // Asynchronous reset while owner 1 drives the bus
        repeat (3) cycle(4'b0010, 4'b0000);
        check_val("pre_rst_drive", {28'd0, drive_en}, 32'h2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        prev_grant = 4'b0000;
        run = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(4'b1111, 4'b0000);
        check_val("post_rst_grant", {28'd0, grant}, 32'h1);

        // Foreign done pulses are ignored while requester 1 owns the bus
        cycle(4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0000);
        repeat (4) cycle(4'b0010, 4'b1000);
        check_val("foreign_done", {28'd0, drive_en}, 32'h2);
        cycle(4'b0010, 4'b0010);
        check_val("own_done_drop", {28'd0, drive_en}, 32'h0);
        repeat (4) cycle(4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
